// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clkdiv_pkg : shared constants and helpers for the clock divider controller
// Rev 1.0
// ---------------------------------------------------------------------------
package clkdiv_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned MIN_DIV = 2;

  // Number of high cycles in a period of n cycles (odd n rounds the high phase up).
  function automatic int unsigned high_phase(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_period_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clkdiv_period_cnt : period counter, wraps at i_last, cleared when not running
// Rev 1.0
// ---------------------------------------------------------------------------
module clkdiv_period_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_run,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt_next,
  output logic         o_wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_wrap     = (cnt_q == i_last);
  assign o_cnt_next = cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_run && !o_wrap) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clkdiv_ctrl : run/stop and divisor-update controller for the integer divider
// Rev 1.0
// ---------------------------------------------------------------------------
module clkdiv_ctrl #(
  parameter int W           = 4,
  parameter int DEFAULT_DIV = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_div_valid,
  input  logic [W-1:0] i_div,
  output logic         o_div_ready,
  output logic         o_clk_div,
  output logic         o_tick,
  output logic         o_busy,
  output logic         o_err,
  output logic [W-1:0] o_div_act
);
  import clkdiv_pkg::*;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         ready_q, ready_d;
  logic         err_q, err_d;
  logic         clk_div_q, clk_div_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;

  logic         w_running;
  logic         w_wrap;
  logic [W-1:0] w_cnt_next;
  logic         w_xfer;
  logic         w_legal;
  logic         w_hold;
  logic         w_run_next;
  logic [W:0]   w_high;

  assign w_running = (state_q != ST_IDLE);
  assign w_xfer    = i_div_valid && ready_q;
  assign w_legal   = (i_div >= W'(MIN_DIV));

  clkdiv_period_cnt #(.W(W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (w_running),
    .i_last     (div_act_q - ONE),
    .o_cnt_next (w_cnt_next),
    .o_wrap     (w_wrap)
  );

  always_comb begin
    state_d    = state_q;
    div_act_d  = div_act_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    err_d      = w_xfer && !w_legal;
    w_hold     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Nothing is being divided, so a new divisor can take effect at once.
        if (pend_q) begin
          div_act_d = pend_div_q;
          pend_d    = 1'b0;
        end
        if (w_xfer && w_legal) begin
          div_act_d = i_div;
          w_hold    = 1'b1;
        end
        if (i_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          state_d = w_wrap ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_en) begin
          state_d = ST_RUN;
        end else if (w_wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A transfer on the boundary cycle is stored, not applied, so it waits a full period.
    if (w_running) begin
      if (w_wrap && pend_q) begin
        div_act_d = pend_div_q;
        pend_d    = 1'b0;
      end
      if (w_xfer && w_legal) begin
        pend_d     = 1'b1;
        pend_div_d = i_div;
      end
    end

    ready_d    = !(pend_d || w_hold);
    w_run_next = (state_d != ST_IDLE);
    busy_d     = w_run_next;
    tick_d     = w_run_next && (w_cnt_next == '0);
    clk_div_d  = w_run_next && ({1'b0, w_cnt_next} < w_high);
  end

  assign w_high = (W+1)'(high_phase(32'(div_act_d)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      div_act_q  <= W'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_act_q  <= div_act_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end

  assign o_div_ready = ready_q;
  assign o_clk_div   = clk_div_q;
  assign o_tick      = tick_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_div_act   = div_act_q;

endmodule
`default_nettype wire
